// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver states
// and the minimum oversampling ratio the bit timer can work with.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Three samples around mid-bit plus margin need at least this many clocks per bit.
    localparam int MIN_BPS_CNT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings an asynchronous serial line into the clock domain and flags high-to-low
// transitions. Everything resets to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic rx_s_q;
    logic rx_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
        end else begin
            meta_q <= din_i;
            rx_s_q <= meta_q;
            rx_d_q <= rx_s_q;
        end
    end

    assign rx_s_o = rx_s_q;
    assign fall_o = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted bit sampling, optional parity,
// one or two stop bits, and a held output word behind a valid/ready handshake.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK       = 50_000_000,
    parameter int BPS       = 9600,
    parameter int BPS_CNT   = CLK / BPS,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 par_err,
    output logic                 frm_err,
    output logic                 overrun,
    output logic                 busy
);

    // Ratios below the minimum cannot hold the three-sample window, so they are raised to it.
    localparam int BPS_EFF = (BPS_CNT < MIN_BPS_CNT) ? MIN_BPS_CNT : BPS_CNT;
    localparam int CW      = $clog2(BPS_EFF);
    localparam int BW      = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MAX = CW'(BPS_EFF - 1);
    localparam logic [CW-1:0] SAMP0   = CW'(BPS_EFF / 2 - 1);
    localparam logic [CW-1:0] SAMP1   = CW'(BPS_EFF / 2);
    localparam logic [CW-1:0] DEC_PT  = CW'(BPS_EFF / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (din),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 vld_q, vld_d;
    logic                 par_q, par_d;
    logic                 frm_q, frm_d;
    logic                 ovr_q, ovr_d;

    logic tick;
    logic decision;
    logic exp_par;
    logic frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            samp_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            par_q      <= 1'b0;
            frm_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            par_q      <= par_d;
            frm_q      <= frm_d;
            ovr_q      <= ovr_d;
        end
    end

    // The timer idles at zero, so entering START always restarts the bit period.
    always_comb begin
        tick       = (cnt_q == DEC_PT);
        decision   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
        exp_par    = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);
        state_d    = state_q;
        cnt_d      = '0;
        samp_d     = samp_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            if (cnt_q == SAMP0) samp_d[0] = rx_s;
            if (cnt_q == SAMP1) samp_d[1] = rx_s;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                if (tick) state_d = decision ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d[bit_idx_q] = decision;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    perr_d  = (decision != exp_par);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!decision) ferr_d = 1'b1;
                    if (stop_idx_q == STOP_LAST) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A finished frame replaces the held word only if it has been or is being taken.
    always_comb begin
        dout_d = dout_q;
        vld_d  = vld_q;
        par_d  = par_q;
        frm_d  = frm_q;
        ovr_d  = 1'b0;

        if (frame_done) begin
            if (!vld_q || dout_rdy) begin
                dout_d = shift_q;
                par_d  = perr_q;
                frm_d  = ferr_d;
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && dout_rdy) begin
            vld_d = 1'b0;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign par_err  = par_q;
    assign frm_err  = frm_q;
    assign overrun  = ovr_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receivers (8N1, 8E1, 8N2) at 115200 baud
// from 50 MHz, each fed directed frames whose expected words are queued on send.
module tb_uart_rx_cfg;

    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 115200;
    localparam int BPS_CNT = CLK_HZ / BAUD;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       frm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       din  [3];
    logic       rdy  [3];
    logic [7:0] dout [3];
    logic       vld  [3];
    logic       perr [3];
    logic       ferr [3];
    logic       ovr  [3];
    logic       busy [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int nChecks = 0;
    int nFails  = 0;
    int ovrSeen [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK(CLK_HZ), .BPS(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .din(din[0]), .dout(dout[0]), .dout_vld(vld[0]), .dout_rdy(rdy[0]),
        .par_err(perr[0]), .frm_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0])
    );

    uart_rx_cfg #(.CLK(CLK_HZ), .BPS(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .din(din[1]), .dout(dout[1]), .dout_vld(vld[1]), .dout_rdy(rdy[1]),
        .par_err(perr[1]), .frm_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1])
    );

    uart_rx_cfg #(.CLK(CLK_HZ), .BPS(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .din(din[2]), .dout(dout[2]), .dout_vld(vld[2]), .dout_rdy(rdy[2]),
        .par_err(perr[2]), .frm_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2])
    );

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bitTime();
        repeat (BPS_CNT) tick();
    endtask

    task automatic pushExp(input int k, input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e = '{data: d, par: p, frm: f};
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int queueSize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic applyStimulus(input int k, input logic [7:0] data, input bit usePar,
                                 input logic parBit, input int nStop, input logic [1:0] stopVals);
        din[k] = 1'b0;
        bitTime();
        for (int i = 0; i < 8; i++) begin
            din[k] = data[i];
            bitTime();
        end
        if (usePar) begin
            din[k] = parBit;
            bitTime();
        end
        for (int s = 0; s < nStop; s++) begin
            din[k] = stopVals[s];
            bitTime();
        end
        din[k] = 1'b1;
    endtask

    task automatic waitDrain(input int k);
        int c = 0;
        while (queueSize(k) != 0 && c < 2 * BPS_CNT) begin
            tick();
            c++;
        end
        nChecks++;
        if (queueSize(k) != 0) begin
            nFails++;
            $display("[TB] FAIL drain_u%0d: %0d words still pending, expected 0", k, queueSize(k));
        end
    endtask

    task automatic checkOutput(input int k);
        exp_t got;
        exp_t e;
        bit   have = 1'b0;
        got = '{data: dout[k], par: perr[k], frm: ferr[k]};
        e   = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        nChecks++;
        if (!have) begin
            nFails++;
            $display("[TB] FAIL unexpected_word_u%0d: got data=%h, expected no word", k, got.data);
        end else if (got !== e) begin
            nFails++;
            $display("[TB] FAIL word_u%0d: got data=%h par=%b frm=%b, expected data=%h par=%b frm=%b",
                     k, got.data, got.par, got.frm, e.data, e.par, e.frm);
        end
    endtask

    // Monitor: every handshake transfer is matched against the head of that receiver's queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (vld[k] && rdy[k]) checkOutput(k);
                if (ovr[k]) ovrSeen[k]++;
            end
        end
    end

    initial begin
        int firstBusy;
        int lastBusy;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[k] = 1'b1;
            rdy[k] = 1'b1;
        end
        repeat (3) tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkVal($sformatf("reset_dout_u%0d", k), dout[k], 0);
            checkVal($sformatf("reset_vld_u%0d", k), vld[k], 0);
            checkVal($sformatf("reset_flags_u%0d", k), {perr[k], ferr[k], ovr[k], busy[k]}, 0);
        end
        tick();
        rst = 1'b0;
        tick();

        pushExp(0, 8'hA5, 1'b0, 1'b0);
        applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11);
        pushExp(0, 8'h01, 1'b0, 1'b0);
        applyStimulus(0, 8'h01, 1'b0, 1'b0, 1, 2'b11);
        pushExp(0, 8'hC3, 1'b0, 1'b1);
        applyStimulus(0, 8'hC3, 1'b0, 1'b0, 1, 2'b00);
        waitDrain(0);

        pushExp(1, 8'h37, 1'b0, 1'b0);
        applyStimulus(1, 8'h37, 1'b1, 1'b1, 1, 2'b11);
        pushExp(1, 8'h37, 1'b1, 1'b0);
        applyStimulus(1, 8'h37, 1'b1, 1'b0, 1, 2'b11);
        waitDrain(1);

        pushExp(2, 8'h5A, 1'b0, 1'b1);
        applyStimulus(2, 8'h5A, 1'b0, 1'b0, 2, 2'b01);
        repeat (8) tick();
        pushExp(2, 8'h3C, 1'b0, 1'b0);
        applyStimulus(2, 8'h3C, 1'b0, 1'b0, 2, 2'b11);
        waitDrain(2);

        firstBusy = -1;
        lastBusy  = -1;
        din[0] = 1'b0;
        for (int c = 0; c < BPS_CNT; c++) begin
            @(negedge clk);
            if (busy[0]) begin
                if (firstBusy < 0) firstBusy = c;
                lastBusy = c;
            end
            if (c == 99) din[0] = 1'b1;
        end
        checkVal("glitch_busy_rise", firstBusy, 3);
        checkVal("glitch_busy_last", lastBusy, 221);
        checkVal("glitch_idle", busy[0], 0);
        bitTime();

        rdy[0] = 1'b0;
        pushExp(0, 8'h11, 1'b0, 1'b0);
        applyStimulus(0, 8'h11, 1'b0, 1'b0, 1, 2'b11);
        applyStimulus(0, 8'h22, 1'b0, 1'b0, 1, 2'b11);
        @(negedge clk);
        checkVal("ovr_vld_held", vld[0], 1);
        checkVal("ovr_dout_held", dout[0], 8'h11);
        checkVal("ovr_pulse_cycles", ovrSeen[0], 1);
        tick();
        rdy[0] = 1'b1;
        waitDrain(0);
        tick();
        tick();
        @(negedge clk);
        checkVal("consume_vld_low", vld[0], 0);
        checkVal("consume_dout_kept", dout[0], 8'h11);

        din[0] = 1'b0;
        bitTime();
        for (int i = 0; i < 3; i++) begin
            din[0] = 1'b1;
            bitTime();
        end
        repeat (200) tick();
        @(negedge clk);
        checkVal("midframe_busy", busy[0], 1);
        tick();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkVal("midrst_dout", dout[0], 0);
        checkVal("midrst_vld", vld[0], 0);
        checkVal("midrst_flags", {perr[0], ferr[0], ovr[0], busy[0]}, 0);
        tick();
        rst = 1'b0;
        repeat (BPS_CNT * 5) tick();
        pushExp(0, 8'h81, 1'b0, 1'b0);
        applyStimulus(0, 8'h81, 1'b0, 1'b0, 1, 2'b11);
        waitDrain(0);

        checkVal("ovr_total_u0", ovrSeen[0], 1);
        checkVal("ovr_total_u1", ovrSeen[1], 0);
        checkVal("ovr_total_u2", ovrSeen[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
